aes_axi_lite_sequencer: RTL

//  AXI4-Lite master that drives the AES register slave (aes_axi_top) on behalf of a streaming client.

---
 rtl/aes_axi_lite_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/aes_axi_lite_sequencer.sv
// AXI4-Lite master that pushes one AES block through the register slave and returns DATA_OUT.
// Strictly one outstanding AXI transaction; any AXI or result-port back-pressure simply stalls the FSM.
module aes_axi_lite_sequencer #(
  parameter logic [31:0] A_CTRL   = 32'h00,
  parameter logic [31:0] A_STATUS = 32'h08,
  parameter logic [31:0] A_MODE   = 32'h0C,
  parameter logic [31:0] A_DIN    = 32'h20,
  parameter logic [31:0] A_IV     = 32'h30,
  parameter logic [31:0] A_DOUT   = 32'h40,
  parameter int          POLL_MAX = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [127:0] cmd_data,
  input  logic [127:0] cmd_iv,
  input  logic [1:0]   cmd_mode,
  input  logic         cmd_decrypt,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_err,
  output logic         busy,
  output logic [31:0]  m_axi_awaddr,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [31:0]  m_axi_wdata,
  output logic [3:0]   m_axi_wstrb,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  input  logic [1:0]   m_axi_bresp,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready,
  output logic [31:0]  m_axi_araddr,
  output logic         m_axi_arvalid,
  input  logic         m_axi_arready,
  input  logic [31:0]  m_axi_rdata,
  input  logic [1:0]   m_axi_rresp,
  input  logic         m_axi_rvalid,
  output logic         m_axi_rready
);

  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_IV, S_WR_DIN, S_WR_MODE, S_WR_CTRL, S_POLL, S_RD_OUT, S_RESP
  } state_t;

  state_t         r_state, w_next;
  logic [1:0]     r_idx;
  logic [PW-1:0]  r_poll;
  logic           r_err, r_aw_done, r_w_done, r_ar_done;
  logic [127:0]   r_data, r_iv, r_dout;
  logic [1:0]     r_mode;
  logic           r_dec;
  logic           w_wr, w_rd, w_cmd_hs, w_b_hs, w_r_hs, w_set_err;
  logic [31:0]    w_off;

  function automatic logic [31:0] f_word(input logic [127:0] v, input logic [1:0] k);
    logic [31:0] w;
    case (k)
      2'd0:    w = v[127:96];
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      default: w = v[31:0];
    endcase
    return w;
  endfunction

  assign w_wr     = (r_state == S_WR_IV) || (r_state == S_WR_DIN) ||
                    (r_state == S_WR_MODE) || (r_state == S_WR_CTRL);
  assign w_rd     = (r_state == S_POLL) || (r_state == S_RD_OUT);
  assign w_off    = {28'b0, r_idx, 2'b00};
  assign w_cmd_hs = cmd_valid && cmd_ready;
  assign w_b_hs   = m_axi_bvalid && m_axi_bready;
  assign w_r_hs   = m_axi_rvalid && m_axi_rready;

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign res_valid     = (r_state == S_RESP);
  assign res_err       = res_valid && r_err;
  assign res_data      = (res_valid && !r_err) ? r_dout : 128'b0;
  assign m_axi_awvalid = w_wr && !r_aw_done;
  assign m_axi_wvalid  = w_wr && !r_w_done;
  assign m_axi_wstrb   = w_wr ? 4'hF : 4'h0;
  assign m_axi_bready  = w_wr;
  assign m_axi_arvalid = w_rd && !r_ar_done;
  assign m_axi_rready  = w_rd;

  always_comb begin
    m_axi_awaddr = 32'b0;
    m_axi_wdata  = 32'b0;
    m_axi_araddr = 32'b0;
    case (r_state)
      S_WR_IV:   begin m_axi_awaddr = A_IV + w_off;  m_axi_wdata = f_word(r_iv, r_idx);   end
      S_WR_DIN:  begin m_axi_awaddr = A_DIN + w_off; m_axi_wdata = f_word(r_data, r_idx); end
      S_WR_MODE: begin m_axi_awaddr = A_MODE; m_axi_wdata = {30'b0, r_mode};        end
      S_WR_CTRL: begin m_axi_awaddr = A_CTRL; m_axi_wdata = {30'b0, r_dec, 1'b1};   end
      S_POLL:    m_axi_araddr = A_STATUS;
      S_RD_OUT:  m_axi_araddr = A_DOUT + w_off;
      default:   ;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next = S_WR_IV;
      S_WR_IV, S_WR_DIN, S_WR_MODE, S_WR_CTRL:
        if (w_b_hs) begin
          if (m_axi_bresp != 2'b00) begin
            w_set_err = 1'b1;
            w_next    = S_RESP;
          end else begin
            case (r_state)
              S_WR_IV:   if (r_idx == 2'd3) w_next = S_WR_DIN;
              S_WR_DIN:  if (r_idx == 2'd3) w_next = S_WR_MODE;
              S_WR_MODE: w_next = S_WR_CTRL;
              default:   w_next = S_POLL;
            endcase
          end
        end
      S_POLL:
        if (w_r_hs) begin
          if (m_axi_rresp != 2'b00) begin
            w_set_err = 1'b1;
            w_next    = S_RESP;
          end else if (m_axi_rdata[1]) begin
            w_next = S_RD_OUT;
          end else if (r_poll == PW'(POLL_MAX - 1)) begin
            w_set_err = 1'b1;
            w_next    = S_RESP;
          end
        end
      S_RD_OUT:
        if (w_r_hs) begin
          if (m_axi_rresp != 2'b00) begin
            w_set_err = 1'b1;
            w_next    = S_RESP;
          end else if (r_idx == 2'd3) begin
            w_next = S_RESP;
          end
        end
      S_RESP:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= 2'd0;
      r_poll    <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_ar_done <= 1'b0;
      r_dout    <= 128'b0;
    end else begin
      if (w_cmd_hs) begin
        r_data <= cmd_data;
        r_iv   <= cmd_iv;
        r_mode <= cmd_mode;
        r_dec  <= cmd_decrypt;
        r_dout <= 128'b0;
        r_err  <= 1'b0;
        r_poll <= '0;
      end
      if (w_set_err) r_err <= 1'b1;
      // AW and W retire independently; B closes the register write as a whole.
      if (w_b_hs) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) r_aw_done <= 1'b1;
        if (m_axi_wvalid && m_axi_wready)   r_w_done  <= 1'b1;
      end
      if (w_r_hs)                                r_ar_done <= 1'b0;
      else if (m_axi_arvalid && m_axi_arready)   r_ar_done <= 1'b1;
      if (w_b_hs || w_r_hs) r_idx <= (w_next != r_state) ? 2'd0 : r_idx + 2'd1;
      if (r_state == S_POLL && w_r_hs && w_next == S_POLL) r_poll <= r_poll + PW'(1);
      // DATA_OUT arrives MSW first, so shifting left leaves word0 in the top bits.
      if (r_state == S_RD_OUT && w_r_hs && m_axi_rresp == 2'b00)
        r_dout <= {r_dout[95:0], m_axi_rdata};
    end
  end

endmodule
